// File: rtl/grf_wb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grf_wb_arbiter_if                                                        |
// | Two write-back request ports and the GRF write port of grf_wb_arbiter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface grf_wb_arbiter_if;
   logic        wb0_valid;
   logic        wb0_ready;
   logic [4:0]  wb0_addr;
   logic [31:0] wb0_data;
   logic        wb1_valid;
   logic        wb1_ready;
   logic [4:0]  wb1_addr;
   logic [31:0] wb1_data;
   logic [4:0]  grf_rw;
   logic [31:0] grf_busw;
   logic        grf_regwrite;

   modport master (
      output wb0_valid, wb0_addr, wb0_data,
      output wb1_valid, wb1_addr, wb1_data,
      input  wb0_ready, wb1_ready,
      input  grf_rw, grf_busw, grf_regwrite
   );

   modport slave (
      input  wb0_valid, wb0_addr, wb0_data,
      input  wb1_valid, wb1_addr, wb1_data,
      output wb0_ready, wb1_ready,
      output grf_rw, grf_busw, grf_regwrite
   );
endinterface
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grf_wb_arbiter                                                           |
// | GRF write-port arbiter: port 0 priority, port 1 starvation escape,       |
// | optional $1..$31 zero sweep after reset. Optional macro GRF_WB_TRACE_EN  |
// | prints each RUN-mode register write.                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module grf_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int INIT_CLEAR   = 1
) (
   input  wire logic       clk,
   input  wire logic       reset,
   grf_wb_arbiter_if.slave bus,
   output logic            init_done,
   output logic [3:0]      starve_cnt_o
);

   localparam logic [0:0] S_INIT  = 1'b0;
   localparam logic [0:0] S_RUN   = 1'b1;
   localparam logic [0:0] C_RST_STATE = (INIT_CLEAR != 0) ? S_INIT : S_RUN;
   localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);
   localparam logic [3:0] C_SAT   = 4'hF;

   logic [0:0]  state_q,  state_d;
   logic [4:0]  ptr_q,    ptr_d;
   logic [3:0]  starve_q, starve_d;
   logic        we_q,     we_d;
   logic [4:0]  rw_q,     rw_d;
   logic [31:0] busw_q,   busw_d;
   logic        done_q,   done_d;

   logic        run;
   logic        force1;
   logic        rdy0;
   logic        rdy1;
   logic        gnt0;
   logic        gnt1;

   always_comb begin
      run    = (state_q == S_RUN);
      force1 = bus.wb1_valid && (starve_q >= C_LIMIT);
      rdy0   = run && !force1;
      rdy1   = run && (force1 || !bus.wb0_valid);
      gnt0   = bus.wb0_valid && rdy0;
      gnt1   = bus.wb1_valid && rdy1;
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      starve_d = starve_q;
      we_d     = 1'b0;
      rw_d     = rw_q;
      busw_d   = busw_q;
      done_d   = run;
      if (!run) begin
         we_d   = 1'b1;
         rw_d   = ptr_q;
         busw_d = '0;
         ptr_d  = ptr_q + 5'd1;
         if (ptr_q == 5'd31) begin
            state_d = S_RUN;
         end
      end else begin
         // A $0 grant completes the handshake but never reaches the GRF.
         if (gnt0 && (bus.wb0_addr != 5'd0)) begin
            we_d   = 1'b1;
            rw_d   = bus.wb0_addr;
            busw_d = bus.wb0_data;
         end else if (gnt1 && (bus.wb1_addr != 5'd0)) begin
            we_d   = 1'b1;
            rw_d   = bus.wb1_addr;
            busw_d = bus.wb1_data;
         end
         // Starvation is only measured while arbitration is live.
         if (!bus.wb1_valid || gnt1) begin
            starve_d = 4'd0;
         end else if (starve_q != C_SAT) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= C_RST_STATE;
         ptr_q    <= 5'd1;
         starve_q <= 4'd0;
         we_q     <= 1'b0;
         rw_q     <= 5'd0;
         busw_q   <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         rw_q     <= rw_d;
         busw_q   <= busw_d;
         done_q   <= done_d;
      end
   end

`ifdef GRF_WB_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && run && we_d) begin
         $display("$%d <= %h", rw_d, busw_d);
      end
   end
`else
`endif

   assign bus.wb0_ready    = rdy0;
   assign bus.wb1_ready    = rdy1;
   assign bus.grf_regwrite = we_q;
   assign bus.grf_rw       = rw_q;
   assign bus.grf_busw     = busw_q;
   assign init_done        = done_q;
   assign starve_cnt_o     = starve_q;

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_grf_wb_arbiter                                                        |
// | Self-checking bench: vector table, directed sequences, random traffic.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_grf_wb_arbiter;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a;
   logic       rst_b;
   logic       done_a;
   logic       done_b;
   logic [3:0] st_a;
   logic [3:0] st_b;

   grf_wb_arbiter_if if_a ();
   grf_wb_arbiter_if if_b ();

   grf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .INIT_CLEAR(1)) u_dut_a (
      .clk(clk), .reset(rst_a), .bus(if_a), .init_done(done_a), .starve_cnt_o(st_a)
   );
   grf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .INIT_CLEAR(0)) u_dut_b (
      .clk(clk), .reset(rst_b), .bus(if_b), .init_done(done_b), .starve_cnt_o(st_b)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic v0; logic [4:0] a0; logic [31:0] d0;
      logic v1; logic [4:0] a1; logic [31:0] d1;
      logic r0; logic r1; logic [3:0] st;
      logic we; logic [4:0] rw; logic [31:0] bw;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic r0, input logic r1, input logic [3:0] st,
                               input logic we, input logic [4:0] rw, input logic [31:0] bw);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.r0 = r0; v.r1 = r1; v.st = st; v.we = we; v.rw = rw; v.bw = bw;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      if_a.wb0_valid = v0; if_a.wb0_addr = a0; if_a.wb0_data = d0;
      if_a.wb1_valid = v1; if_a.wb1_addr = a1; if_a.wb1_data = d1;
   endtask

   task automatic sweep_from(input int first);
      for (int i = first; i <= 31; i++) begin
         chk("sweep_rdy0", 32'(if_a.wb0_ready), 32'd0);
         chk("sweep_rdy1", 32'(if_a.wb1_ready), 32'd0);
         tick();
         chk("sweep_we", 32'(if_a.grf_regwrite), 32'd1);
         chk("sweep_rw", 32'(if_a.grf_rw), 32'(i));
         chk("sweep_busw", if_a.grf_busw, 32'd0);
         chk("sweep_done", 32'(done_a), 32'd0);
      end
      tick();
      chk("done_rise", 32'(done_a), 32'd1);
      chk("done_we", 32'(if_a.grf_regwrite), 32'd0);
   endtask

   // Reference model state (random phase)
   int          m_starve;
   logic [4:0]  m_rw;
   logic [31:0] m_bw;
   logic [31:0] model_rf [32];
   logic [31:0] dut_rf   [32];

   initial begin
      logic v0, v1, hold0, hold1, frc, e0, e1, g0, g1, ew;
      logic [4:0] a0, a1;
      logic [31:0] d0, d1;

      rst_a = 1'b1;
      rst_b = 1'b1;
      drive_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      if_b.wb0_valid = 1'b0; if_b.wb0_addr = 5'd0; if_b.wb0_data = 32'd0;
      if_b.wb1_valid = 1'b0; if_b.wb1_addr = 5'd0; if_b.wb1_data = 32'd0;

      vecs[0]  = mk(1, 5'd5, 32'h1234,     0, 5'd0,  32'h0,  1, 0, 4'd0, 1, 5'd5,  32'h1234);
      vecs[1]  = mk(1, 5'd3, 32'hA,        1, 5'd7,  32'hB,  1, 0, 4'd0, 1, 5'd3,  32'hA);
      vecs[2]  = mk(1, 5'd3, 32'hA,        1, 5'd7,  32'hB,  1, 0, 4'd1, 1, 5'd3,  32'hA);
      vecs[3]  = mk(1, 5'd3, 32'hA,        1, 5'd7,  32'hB,  1, 0, 4'd2, 1, 5'd3,  32'hA);
      vecs[4]  = mk(1, 5'd3, 32'hA,        1, 5'd7,  32'hB,  1, 0, 4'd3, 1, 5'd3,  32'hA);
      vecs[5]  = mk(1, 5'd3, 32'hA,        1, 5'd7,  32'hB,  0, 1, 4'd4, 1, 5'd7,  32'hB);
      vecs[6]  = mk(1, 5'd3, 32'hA,        1, 5'd7,  32'hB,  1, 0, 4'd0, 1, 5'd3,  32'hA);
      vecs[7]  = mk(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0,  32'h0,  1, 0, 4'd1, 0, 5'd3,  32'hA);
      vecs[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0,  32'h0,  1, 1, 4'd0, 0, 5'd3,  32'hA);
      vecs[9]  = mk(0, 5'd0, 32'h0,        1, 5'd31, 32'h55, 1, 1, 4'd0, 1, 5'd31, 32'h55);
      vecs[10] = mk(0, 5'd0, 32'h0,        1, 5'd0,  32'h77, 1, 1, 4'd0, 0, 5'd31, 32'h55);

      tick();
      tick();
      chk("rst_we", 32'(if_a.grf_regwrite), 32'd0);
      chk("rst_rw", 32'(if_a.grf_rw), 32'd0);
      chk("rst_busw", if_a.grf_busw, 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_starve", 32'(st_a), 32'd0);
      chk("rst_b_we", 32'(if_b.grf_regwrite), 32'd0);
      chk("rst_b_done", 32'(done_b), 32'd0);

      // Power-on sweep
      rst_a = 1'b0;
      sweep_from(1);

      // Table-driven arbitration vectors
      for (int k = 0; k < 11; k++) begin
         drive_a(vecs[k].v0, vecs[k].a0, vecs[k].d0, vecs[k].v1, vecs[k].a1, vecs[k].d1);
         #1;
         chk($sformatf("vec%0d_rdy0", k), 32'(if_a.wb0_ready), 32'(vecs[k].r0));
         chk($sformatf("vec%0d_rdy1", k), 32'(if_a.wb1_ready), 32'(vecs[k].r1));
         chk($sformatf("vec%0d_starve", k), 32'(st_a), 32'(vecs[k].st));
         tick();
         chk($sformatf("vec%0d_we", k), 32'(if_a.grf_regwrite), 32'(vecs[k].we));
         chk($sformatf("vec%0d_rw", k), 32'(if_a.grf_rw), 32'(vecs[k].rw));
         chk($sformatf("vec%0d_busw", k), if_a.grf_busw, vecs[k].bw);
      end

      // Random traffic against the reference model
      m_starve = 0;
      m_rw = 5'd31;
      m_bw = 32'h55;
      for (int r = 0; r < 32; r++) begin
         model_rf[r] = 32'd0;
         dut_rf[r]   = 32'd0;
      end
      hold0 = 1'b0; hold1 = 1'b0;
      v0 = 1'b0; v1 = 1'b0; a0 = 5'd0; a1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
      for (int c = 0; c < 400; c++) begin
         if (!hold0) begin
            v0 = ($urandom_range(0, 99) < 60);
            a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            d0 = $urandom;
         end
         if (!hold1) begin
            v1 = ($urandom_range(0, 99) < 50);
            a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            d1 = $urandom;
         end
         drive_a(v0, a0, d0, v1, a1, d1);
         #1;
         frc = v1 && (m_starve >= LIMIT);
         e0  = !frc;
         e1  = frc || !v0;
         chk("rand_rdy0", 32'(if_a.wb0_ready), 32'(e0));
         chk("rand_rdy1", 32'(if_a.wb1_ready), 32'(e1));
         chk("rand_starve", 32'(st_a), 32'(m_starve));
         g0 = v0 && e0;
         g1 = v1 && e1;
         ew = 1'b0;
         if (g0 && (a0 != 5'd0)) begin
            ew = 1'b1; m_rw = a0; m_bw = d0;
         end else if (g1 && (a1 != 5'd0)) begin
            ew = 1'b1; m_rw = a1; m_bw = d1;
         end
         if (ew) model_rf[m_rw] = m_bw;
         m_starve = (!v1 || g1) ? 0 : ((m_starve < 15) ? m_starve + 1 : 15);
         hold0 = v0 && !g0;
         hold1 = v1 && !g1;
         tick();
         chk("rand_we", 32'(if_a.grf_regwrite), 32'(ew));
         chk("rand_rw", 32'(if_a.grf_rw), 32'(m_rw));
         chk("rand_busw", if_a.grf_busw, m_bw);
         if (if_a.grf_regwrite) dut_rf[if_a.grf_rw] = if_a.grf_busw;
      end
      for (int r = 1; r < 32; r++) begin
         chk($sformatf("rf_r%0d", r), dut_rf[r], model_rf[r]);
      end

      // Reset during RUN discards the grant seen in the reset cycle
      drive_a(1'b1, 5'd12, 32'hBEEF, 1'b0, 5'd0, 32'd0);
      rst_a = 1'b1;
      tick();
      chk("rstrun_we", 32'(if_a.grf_regwrite), 32'd0);
      chk("rstrun_rw", 32'(if_a.grf_rw), 32'd0);
      chk("rstrun_done", 32'(done_a), 32'd0);
      chk("rstrun_starve", 32'(st_a), 32'd0);
      rst_a = 1'b0;
      drive_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk("pre_rw", 32'(if_a.grf_rw), 32'(i));
      end

      // Reset with sweep pointer at 10 and a wb0 request pending
      drive_a(1'b1, 5'd12, 32'hBEEF, 1'b0, 5'd0, 32'd0);
      rst_a = 1'b1;
      tick();
      chk("mid_we", 32'(if_a.grf_regwrite), 32'd0);
      chk("mid_rw", 32'(if_a.grf_rw), 32'd0);
      rst_a = 1'b0;
      drive_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sweep_from(1);

      // INIT_CLEAR=0 instance
      if_b.wb1_valid = 1'b1; if_b.wb1_addr = 5'd31; if_b.wb1_data = 32'h55;
      tick();
      chk("b_rst_we", 32'(if_b.grf_regwrite), 32'd0);
      chk("b_rst_done", 32'(done_b), 32'd0);
      rst_b = 1'b0;
      #1;
      chk("b_rdy0", 32'(if_b.wb0_ready), 32'd1);
      chk("b_rdy1", 32'(if_b.wb1_ready), 32'd1);
      tick();
      chk("b_we", 32'(if_b.grf_regwrite), 32'd1);
      chk("b_rw", 32'(if_b.grf_rw), 32'd31);
      chk("b_busw", if_b.grf_busw, 32'h55);
      chk("b_done", 32'(done_b), 32'd1);
      if_b.wb1_valid = 1'b0;
      tick();
      chk("b_idle_we", 32'(if_b.grf_regwrite), 32'd0);
      chk("b_idle_rw", 32'(if_b.grf_rw), 32'd31);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
Owns the single write port of the 32x32 general register file (GRF). It shares that port between two write-back requesters: the main pipeline (port 0) and a multi-cycle unit such as mult/div (port 1). Port 0 has fixed priority, with a starvation escape for port 1. After reset it optionally sweeps registers $1..$31 to zero before accepting requests.

Parameters:
STARVE_LIMIT, 4, consecutive stalled cycles of req1 before req1 is forced ahead of req0 (1..15)
INIT_CLEAR, 1, 1 = run the zero-sweep of $1..$31 after reset; 0 = go straight to RUN

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
wb0_valid  input  1  pipeline write-back request
wb0_ready  output  1  port 0 accepted this cycle when valid&ready
wb0_addr  input  5  destination register, port 0
wb0_data  input  32  write data, port 0
wb1_valid  input  1  multi-cycle unit write-back request
wb1_ready  output  1  port 1 accepted this cycle when valid&ready
wb1_addr  input  5  destination register, port 1
wb1_data  input  32  write data, port 1
grf_rw  output  5  to GRF RW
grf_busw  output  32  to GRF busW
grf_regwrite  output  1  to GRF RegWrite
init_done  output  1  high once state is RUN
starve_cnt_o  output  4  current port 1 starvation count, for debug

Behaviour:
- Every output is registered except the ready signals.
- Reset (sync, high) sets: state=INIT if INIT_CLEAR else RUN, init pointer=1, grf_regwrite=0, grf_rw=0, grf_busw=0, init_done=0, starve count=0.
- Reset asserted mid-sweep or mid-transfer restarts everything. A grant accepted in the reset cycle is discarded.
- States:
  - INIT: each cycle drives grf_regwrite=1, grf_rw=ptr, grf_busw=0, then ptr++. After ptr=31 is written, the next state is RUN. The sweep takes 31 cycles.
  - RUN: arbitration.
- Ready signals are 0 in INIT.
- force1 = wb1_valid && (starve >= STARVE_LIMIT).
- In RUN:
  - wb0_ready = !force1
  - wb1_ready = force1 || !wb0_valid
- Exactly one grant per cycle at most.
- Grant in cycle t means grf_regwrite=1, with the granted addr/data on grf_rw/grf_busw, in cycle t+1. Latency is 1 cycle, and the port is never written twice per cycle.
- No grant in RUN means grf_regwrite=0. grf_rw and grf_busw hold their last values.
- Writes to $0:
  - The handshake completes (ready honoured).
  - grf_regwrite stays 0 the next cycle.
  - This counts as a grant for starvation purposes.
- Starvation counter:
  - Increments when wb1_valid && !wb1_ready, saturating at 15.
  - Clears on a port 1 grant or when wb1_valid=0.
  - A forced grant clears it, so port 0 regains priority the following cycle.
- Requesters must hold addr/data stable while valid && !ready. The block does not latch unaccepted requests.
- Same addr on both ports in the same cycle: only the granted one is written. The other retries later, and its later write wins.

Optional Feature:
- Macro: GRF_WB_TRACE_EN.
- Defined: on every cycle with grf_regwrite=1 in RUN, simulation prints "$%d <= %h" (decimal reg, hex data) via $display. INIT writes are not printed.
- Undefined: no display statements are compiled, and RTL behaviour is identical.

Test Plan:
1. INIT_CLEAR=1, reset high 2 cycles then low:
   - grf_regwrite=1 for exactly 31 cycles with grf_rw=1..31 and grf_busw=0.
   - init_done rises the cycle after rw=31.
   - Ready signals are 0 throughout.
2. RUN, wb0 valid addr=5 data=0x1234 only:
   - wb0_ready=1.
   - Next cycle: grf_regwrite=1, grf_rw=5, grf_busw=0x00001234.
3. Both valid continuously:
   - wb0 addr=3 / data=0xA, wb1 addr=7 / data=0xB, STARVE_LIMIT=4.
   - Required: 4 port-0 grants, then 1 port-1 grant (rw=7, busw=0xB), then port 0 again.
   - starve_cnt_o reads 0,1,2,3,4,0.
4. wb0 valid addr=0 data=0xFFFF_FFFF:
   - Handshake completes.
   - grf_regwrite stays 0 the next cycle.
5. Reset asserted at sweep pointer 10:
   - The sweep restarts at rw=1 the cycle after reset drops.
   - A wb0 request pending during reset is not written.
6. INIT_CLEAR=0:
   - init_done=1 and ready available in the first cycle after reset.
   - wb1-only request addr=31 data=0x55 is written next cycle.
